// File: rtl/viterbi_acs.sv
// viterbi_acs: K=3 rate-1/2 (7,5) hard-decision add-compare-select over 8-symbol blocks,
// followed by a 9-cycle traceback strobe window.
module viterbi_acs (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [1:0] i_sym,
  output logic       o_ready,
  output logic       en_mem,
  output logic [1:0] o_prev_st_00,
  output logic [1:0] o_prev_st_10,
  output logic [1:0] o_prev_st_01,
  output logic [1:0] o_prev_st_11,
  output logic [1:0] o_best_st,
  output logic [3:0] o_best_pm,
  output logic       o_done
);
  typedef enum logic [1:0] {ACS, TRACE, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] pm [4];
  logic [3:0] c0 [4];
  logic [3:0] c1 [4];
  logic [3:0] win [4];
  logic [3:0] dec;
  logic [3:0] cnt, tcnt, ofs, ofs_nx, mn;
  logic [4:0] ofs_sum;
  logic [1:0] bi;
  logic       take;

  function automatic logic [3:0] cand(input logic [1:0] t, input logic p0, input logic [3:0] m,
                                      input logic [1:0] sym);
    logic [4:0] s;
    s = {1'b0, m} + {4'd0, t[1] ^ t[0] ^ p0 ^ sym[1]} + {4'd0, t[1] ^ p0 ^ sym[0]};
    return s[4] ? 4'd15 : s[3:0];
  endfunction

  // Target state t={u,a} is reached from {a,0} (c0) or {a,1} (c1); ties keep s0=0.
  for (genvar t = 0; t < 4; t++) begin : g_acs
    assign c0[t]  = cand(2'(t), 1'b0, pm[2 * (t % 2)], i_sym);
    assign c1[t]  = cand(2'(t), 1'b1, pm[2 * (t % 2) + 1], i_sym);
    assign dec[t] = c1[t] < c0[t];
    assign win[t] = dec[t] ? c1[t] : c0[t];
  end

  // ofs accumulates every normalisation offset, so it equals the absolute best metric.
  always_comb begin
    bi = 2'd0;
    for (int i = 1; i < 4; i++) bi = (win[i] < win[bi]) ? 2'(i) : bi;
    mn = win[bi];
    ofs_sum = {1'b0, ofs} + {1'b0, mn};
    ofs_nx = ofs_sum[4] ? 4'd15 : ofs_sum[3:0];
  end

  assign o_ready = state == ACS;
  assign o_done  = state == DONE;
  assign take    = i_valid && o_ready;

  always_comb begin
    state_nx = (take && cnt == 4'd7) ? TRACE : (state == TRACE && tcnt == 4'd9) ? DONE : state;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACS;
    else state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm <= '{4'd0, 4'd15, 4'd15, 4'd15};
      cnt <= 4'd0;
      tcnt <= 4'd0;
      ofs <= 4'd0;
      en_mem <= 1'b0;
      o_prev_st_00 <= 2'd0;
      o_prev_st_01 <= 2'd0;
      o_prev_st_10 <= 2'd0;
      o_prev_st_11 <= 2'd0;
      o_best_st <= 2'd0;
      o_best_pm <= 4'd0;
    end else begin
      en_mem <= take || (state == TRACE && tcnt != 4'd9);
      if (state == TRACE) tcnt <= tcnt + 4'd1;
      if (take) begin
        for (int i = 0; i < 4; i++) pm[i] <= win[i] - mn;
        cnt <= cnt + 4'd1;
        ofs <= ofs_nx;
        o_prev_st_00 <= {1'b0, dec[0]};
        o_prev_st_01 <= {1'b1, dec[1]};
        o_prev_st_10 <= {1'b0, dec[2]};
        o_prev_st_11 <= {1'b1, dec[3]};
        if (cnt == 4'd7) begin
          o_best_st <= bi;
          o_best_pm <= ofs_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_viterbi_acs.sv
// tb_viterbi_acs: directed and randomized blocks checked against an exhaustive
// maximum-likelihood search over all 256 input sequences.
module tb_viterbi_acs;
  logic       clk = 1'b0;
  logic       rst, i_valid;
  logic [1:0] i_sym;
  logic       o_ready, en_mem, o_done;
  logic [1:0] o_prev_st_00, o_prev_st_10, o_prev_st_01, o_prev_st_11, o_best_st;
  logic [3:0] o_best_pm;
  int         errs = 0, checks = 0;
  logic [1:0] syms [8];
  logic [1:0] exp_st;
  logic [3:0] exp_pm;

  viterbi_acs dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sym(i_sym), .o_ready(o_ready),
    .en_mem(en_mem), .o_prev_st_00(o_prev_st_00), .o_prev_st_10(o_prev_st_10),
    .o_prev_st_01(o_prev_st_01), .o_prev_st_11(o_prev_st_11), .o_best_st(o_best_st),
    .o_best_pm(o_best_pm), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic encode(input logic [7:0] bits);
    logic [1:0] s;
    logic       u;
    s = 2'd0;
    for (int i = 0; i < 8; i++) begin
      u = bits[i];
      syms[i] = {u ^ s[1] ^ s[0], u ^ s[0]};
      s = {u, s[1]};
    end
  endtask

  // Best end state = lowest numbered state reached by a minimum-distance codeword.
  task automatic model();
    int         best [4];
    int         d;
    logic [1:0] s, c, x;
    logic       u;
    for (int i = 0; i < 4; i++) best[i] = 1000;
    for (int q = 0; q < 256; q++) begin
      s = 2'd0;
      d = 0;
      for (int i = 0; i < 8; i++) begin
        u = q[i];
        c = {u ^ s[1] ^ s[0], u ^ s[0]};
        x = c ^ syms[i];
        d += int'(x[1]) + int'(x[0]);
        s = {u, s[1]};
      end
      if (d < best[s]) best[s] = d;
    end
    exp_st = 2'd0;
    for (int i = 1; i < 4; i++) if (best[i] < best[exp_st]) exp_st = 2'(i);
    exp_pm = best[exp_st] > 15 ? 4'd15 : 4'(best[exp_st]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_block(input bit gap, input bit allzero);
    int k = 0, en = 0, falls = 0, cyc = 0;
    bit took, prev_en = 0;
    while (o_done !== 1'b1 && cyc < 200) begin
      i_valid = (k >= 8) || !gap || (cyc % 3 == 0);
      took = i_valid && o_ready;
      i_sym = (took && k < 8) ? syms[k] : 2'($urandom);
      tick();
      cyc++;
      if (took) begin
        k++;
        if (allzero) chk("prev00_zero", 8'(o_prev_st_00), 8'd0);
        if (allzero && k == 1) chk("prev10_first", 8'(o_prev_st_10), 8'd0);
      end
      if (en_mem) en++;
      if (prev_en && !en_mem && !o_done) falls++;
      prev_en = en_mem;
    end
    chk("done", 8'(o_done), 8'd1);
    chk("accepts", 8'(k), 8'd8);
    chk("en_mem_cycles", 8'(en), 8'd17);
    chk("en_mem_gaps", 8'(falls), gap ? 8'd7 : 8'd0);
    chk("en_mem_done", 8'(en_mem), 8'd0);
    chk("ready_done", 8'(o_ready), 8'd0);
    model();
    chk("best_st_model", 8'(o_best_st), 8'(exp_st));
    chk("best_pm_model", 8'(o_best_pm), 8'(exp_pm));
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_sym = 2'($urandom);
      tick();
    end
    chk("done_hold", {o_done, en_mem, o_ready, 1'b0, o_best_pm}, {3'b100, 1'b0, exp_pm});
    chk("best_st_hold", 8'(o_best_st), 8'(exp_st));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_prev"}, {o_prev_st_00, o_prev_st_01, o_prev_st_10, o_prev_st_11}, 8'd0);
    chk({tag, "_en"}, 8'(en_mem), 8'd0);
    chk({tag, "_best"}, {o_best_st, 2'b00, o_best_pm}, 8'd0);
    chk({tag, "_done"}, 8'(o_done), 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_sym = 2'd0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    chk("ready_after_reset", 8'(o_ready), 8'd1);
    for (int i = 0; i < 5; i++) begin
      i_sym = 2'($urandom);
      tick();
      chk("idle_en", 8'(en_mem), 8'd0);
    end
    for (int i = 0; i < 8; i++) syms[i] = 2'b00;
    run_block(0, 1);
    chk("zero_best_st", 8'(o_best_st), 8'd0);
    chk("zero_best_pm", 8'(o_best_pm), 8'd0);

    do_reset();
    encode(8'b0000_1101);
    chk("encode_sym3", 8'(syms[3]), 8'b01);
    run_block(0, 0);
    chk("clean_best_st", 8'(o_best_st), 8'd0);
    chk("clean_best_pm", 8'(o_best_pm), 8'd0);

    do_reset();
    encode(8'b0000_1101);
    syms[2] = 2'b10;
    run_block(1, 0);
    chk("err_best_st", 8'(o_best_st), 8'd0);
    chk("err_best_pm", 8'(o_best_pm), 8'd1);

    for (int r = 0; r < 10; r++) begin
      do_reset();
      encode(8'($urandom));
      for (int f = $urandom_range(0, 2); f > 0; f--) begin
        int idx = $urandom_range(0, 7);
        int b = $urandom_range(0, 1);
        syms[idx][b] = ~syms[idx][b];
      end
      run_block(r % 2 == 1, 0);
    end

    do_reset();
    encode(8'b0000_1101);
    syms[2] = 2'b10;
    i_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_sym = syms[i];
      tick();
    end
    chk("trace_entry_ready", 8'(o_ready), 8'd0);
    tick();
    tick();
    tick();
    chk("trace4_en", 8'(en_mem), 8'd1);
    rst = 1'b1;
    tick();
    chk_reset_vals("midtrace_reset");
    rst = 1'b0;
    i_valid = 1'b0;
    chk("ready_after_midtrace", 8'(o_ready), 8'd1);
    encode(8'($urandom));
    run_block(0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
